addsub_rr_arbiter: RTL and testbench

Shares one 4-bit two's-complement adder/subtractor datapath (A, B, K in; SUM, overflow out) among NREQ requesters.
- Round-robin arbitration picks one requester.
- Its operands are registered onto the datapath inputs.
- The combinational result is captured one cycle later and returned with the requester ID over a valid/ready response channel.
- Running operation and overflow counters are kept for software/debug.

---
 rtl/addsub_rr_arbiter_if.sv | 27 ++
 rtl/addsub_rr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_addsub_rr_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_rr_arbiter_if.sv
// Request and response channels between the requesters/consumer and the
// shared add/sub arbiter.
interface addsub_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) ();
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_k;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_sum;
    logic              rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_k, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_k, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf
    );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin sharing of one external 4-bit add/sub datapath among NREQ
// requesters, with a valid/ready response channel and saturating statistics.
module addsub_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_rr_arbiter_if.slave bus,
    output logic [3:0]         as_a,
    output logic [3:0]         as_b,
    output logic               as_k,
    input  logic [3:0]         as_sum,
    input  logic               as_ovf,
    output logic               busy,
    output logic [CNTW-1:0]    op_count,
    output logic [CNTW-1:0]    ovf_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [3:0]      as_a_q, as_a_d;
    logic [3:0]      as_b_q, as_b_d;
    logic            as_k_q, as_k_d;
    // Doubles as the stored ID of the operation in flight.
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [3:0]      rsp_sum_q, rsp_sum_d;
    logic            rsp_ovf_q, rsp_ovf_d;
    logic [CNTW-1:0] op_count_q, op_count_d;
    logic [CNTW-1:0] ovf_count_q, ovf_count_d;

    logic [3:0]      req_a_arr [NREQ];
    logic [3:0]      req_b_arr [NREQ];
    logic            req_k_arr [NREQ];

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW:0]    cand_w;
    logic            grant_en;
    logic [NREQ-1:0] req_ready_vec;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_a_arr[gi] = bus.req_a[4*gi +: 4];
            assign req_b_arr[gi] = bus.req_b[4*gi +: 4];
            assign req_k_arr[gi] = bus.req_k[gi];
        end
    endgenerate

    // Search starts just after the last winner and wraps modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_w      = '0;
        for (int s = 1; s <= NREQ; s++) begin
            cand_w = {1'b0, last_grant_q} + (IDW+1)'(s);
            if (cand_w >= (IDW+1)'(NREQ)) begin
                cand_w = cand_w - (IDW+1)'(NREQ);
            end
            if (!grant_found && bus.req_valid[cand_w[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_w[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_found) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != S_IDLE);
        grant_en      = (state_q == S_IDLE) && grant_found;
        req_ready_vec = '0;
        if (grant_en) begin
            req_ready_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        as_a_d       = as_a_q;
        as_b_d       = as_b_q;
        as_k_d       = as_k_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_ovf_d    = rsp_ovf_q;
        op_count_d   = op_count_q;
        ovf_count_d  = ovf_count_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    as_a_d       = req_a_arr[grant_idx];
                    as_b_d       = req_b_arr[grant_idx];
                    as_k_d       = req_k_arr[grant_idx];
                    last_grant_d = grant_idx;
                end
            end
            S_EXEC: begin
                rsp_sum_d   = as_sum;
                rsp_ovf_d   = as_ovf;
                rsp_id_d    = last_grant_q;
                rsp_valid_d = 1'b1;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + CNTW'(1);
                    end
                    if (rsp_ovf_q && (ovf_count_q != '1)) begin
                        ovf_count_d = ovf_count_q + CNTW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            as_a_q       <= '0;
            as_b_q       <= '0;
            as_k_q       <= 1'b0;
            last_grant_q <= IDW'(NREQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_ovf_q    <= 1'b0;
            op_count_q   <= '0;
            ovf_count_q  <= '0;
        end else begin
            as_a_q       <= as_a_d;
            as_b_q       <= as_b_d;
            as_k_q       <= as_k_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_ovf_q    <= rsp_ovf_d;
            op_count_q   <= op_count_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign bus.req_ready = req_ready_vec;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign as_a          = as_a_q;
    assign as_b          = as_b_q;
    assign as_k          = as_k_q;
    assign op_count      = op_count_q;
    assign ovf_count     = ovf_count_q;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Scoreboard bench for addsub_rr_arbiter: a 4-requester instance for function,
// fairness, backpressure and reset, plus a 1-requester CNTW=4 instance for saturation.
`timescale 1ns/1ps
module tb_addsub_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;

    addsub_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_if ();
    addsub_rr_arbiter_if #(.NREQ(1), .IDW(1)) bus2_if ();

    logic [3:0]  as_a, as_b, as_sum;
    logic        as_k, as_ovf, busy;
    logic [15:0] op_count, ovf_count;

    logic [3:0]  as2_a, as2_b, as2_sum;
    logic        as2_k, as2_ovf, busy2;
    logic [3:0]  op_count2, ovf_count2;

    addsub_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if),
        .as_a(as_a), .as_b(as_b), .as_k(as_k), .as_sum(as_sum), .as_ovf(as_ovf),
        .busy(busy), .op_count(op_count), .ovf_count(ovf_count)
    );

    addsub_rr_arbiter #(.NREQ(1), .IDW(1), .CNTW(4)) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2_if),
        .as_a(as2_a), .as_b(as2_b), .as_k(as2_k), .as_sum(as2_sum), .as_ovf(as2_ovf),
        .busy(busy2), .op_count(op_count2), .ovf_count(ovf_count2)
    );

    // External datapath: bit-level wrap-around and sign-bit overflow rule.
    assign as_sum  = as_k ? (as_a - as_b) : (as_a + as_b);
    assign as_ovf  = as_k ? ((as_a[3] != as_b[3]) && (as_sum[3] != as_a[3]))
                          : ((as_a[3] == as_b[3]) && (as_sum[3] != as_a[3]));
    assign as2_sum = as2_k ? (as2_a - as2_b) : (as2_a + as2_b);
    assign as2_ovf = as2_k ? ((as2_a[3] != as2_b[3]) && (as2_sum[3] != as2_a[3]))
                           : ((as2_a[3] == as2_b[3]) && (as2_sum[3] != as2_a[3]));

    typedef struct {
        logic [IDW-1:0] id;
        logic [3:0]     sum;
        logic           ovf;
    } exp_t;

    exp_t            sb[$];
    int              grant_id_log[$];
    int              grant_cyc_log[$];
    logic [NREQ-1:0] hold_mask;
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              n_rsp2 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Signed integer reference: {ovf, sum}.
    function automatic logic [4:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic k);
        int sa, sb_v, r;
        sa   = $signed(a);
        sb_v = $signed(b);
        r    = k ? (sa - sb_v) : (sa + sb_v);
        return {((r > 7) || (r < -8)), r[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic k);
        bus_if.req_a[4*i +: 4] = a;
        bus_if.req_b[4*i +: 4] = b;
        bus_if.req_k[i]        = k;
        bus_if.req_valid[i]    = 1'b1;
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grant_id_log.size() < n && t < 200) begin
            tick();
            t++;
        end
        chk("grant_wait_timeout", 32'(t >= 200), 0);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((sb.size() != 0 || busy || bus_if.req_valid != '0) && t < 200) begin
            tick();
            t++;
        end
        chk(tag, 32'(t >= 200), 0);
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        bus_if.req_valid = '0;
        hold_mask        = '0;
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    always @(posedge clk) cyc++;

    // Main-instance monitor: scoreboard push on grant, compare while rsp_valid.
    always @(negedge clk) begin
        logic [NREQ-1:0] acc;
        logic [4:0]      r;
        exp_t            e;
        acc = bus_if.req_valid & bus_if.req_ready;
        if (rst_n && acc != '0) begin
            chk("grant_onehot", 32'($countones(acc)), 1);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    r     = ref_op(bus_if.req_a[4*i +: 4], bus_if.req_b[4*i +: 4], bus_if.req_k[i]);
                    e.id  = IDW'(i);
                    e.sum = r[3:0];
                    e.ovf = r[4];
                    sb.push_back(e);
                    grant_id_log.push_back(i);
                    grant_cyc_log.push_back(cyc);
                end
            end
        end
        if (rst_n && bus_if.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus_if.rsp_valid), 0);
            end else begin
                chk("rsp_id", 32'(bus_if.rsp_id), 32'(sb[0].id));
                chk("rsp_sum", 32'(bus_if.rsp_sum), 32'(sb[0].sum));
                chk("rsp_ovf", 32'(bus_if.rsp_ovf), 32'(sb[0].ovf));
                if (bus_if.rsp_ready) begin
                    $display("rsp id=%0d sum=%h ovf=%0b cycle=%0d", bus_if.rsp_id,
                             bus_if.rsp_sum, bus_if.rsp_ovf, cyc);
                    void'(sb.pop_front());
                end
            end
        end
        if (acc != '0) begin
            @(posedge clk);
            #1;
            bus_if.req_valid = bus_if.req_valid & ~(acc & ~hold_mask);
        end
    end

    // Saturation-instance monitor: always a=7 b=1 add, so 8 with overflow.
    always @(negedge clk) begin
        if (rst2_n && bus2_if.rsp_valid && bus2_if.rsp_ready) begin
            chk("n1_rsp_id", 32'(bus2_if.rsp_id), 0);
            chk("n1_rsp_sum", 32'(bus2_if.rsp_sum), 32'h8);
            chk("n1_rsp_ovf", 32'(bus2_if.rsp_ovf), 1);
            n_rsp2++;
            $display("n1 rsp #%0d sum=%h op_count=%0d", n_rsp2, bus2_if.rsp_sum, op_count2);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int rise_cyc;
        int t;
        int exp_rr[6];
        rst_n             = 1'b0;
        rst2_n            = 1'b0;
        hold_mask         = '0;
        bus_if.req_valid  = '0;
        bus_if.req_a      = '0;
        bus_if.req_b      = '0;
        bus_if.req_k      = '0;
        bus_if.rsp_ready  = 1'b1;
        bus2_if.req_valid = '0;
        bus2_if.req_a     = '0;
        bus2_if.req_b     = '0;
        bus2_if.req_k     = '0;
        bus2_if.rsp_ready = 1'b1;
        repeat (3) tick();

        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
        chk("rst_rsp_id", 32'(bus_if.rsp_id), 0);
        chk("rst_rsp_sum", 32'(bus_if.rsp_sum), 0);
        chk("rst_as_a", 32'(as_a), 0);
        chk("rst_as_b", 32'(as_b), 0);
        chk("rst_as_k", 32'(as_k), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_ovf_count", 32'(ovf_count), 0);
        rst_n = 1'b1;

        // Single add, latency and operand registration.
        set_req(0, 4'd3, 4'd2, 1'b0);
        @(negedge clk);
        chk("add_req_ready", 32'(bus_if.req_ready), 32'h1);
        tick();
        chk("add_exec_busy", 32'(busy), 1);
        chk("add_exec_rsp_valid", 32'(bus_if.rsp_valid), 0);
        chk("add_as_a", 32'(as_a), 3);
        chk("add_as_b", 32'(as_b), 2);
        chk("add_as_k", 32'(as_k), 0);
        chk("add_exec_req_ready", 32'(bus_if.req_ready), 0);
        tick();
        chk("add_rsp_valid_2cyc", 32'(bus_if.rsp_valid), 1);
        wait_drain("add_drain_timeout");
        chk("add_op_count", 32'(op_count), 1);

        // Overflow and subtract cases.
        apply_reset();
        set_req(1, 4'd7, 4'd1, 1'b0);
        wait_drain("ovf1_drain_timeout");
        set_req(2, 4'd4, 4'd6, 1'b1);
        wait_drain("sub_drain_timeout");
        set_req(3, 4'd8, 4'd1, 1'b1);
        wait_drain("ovf2_drain_timeout");
        chk("seq_op_count", 32'(op_count), 3);
        chk("seq_ovf_count", 32'(ovf_count), 2);

        // Fairness with all four requesters held valid.
        apply_reset();
        grant_id_log.delete();
        grant_cyc_log.delete();
        hold_mask = 4'hF;
        for (int i = 0; i < NREQ; i++) set_req(i, 4'(i), 4'(i + 1), 1'(i & 1));
        wait_grants(6);
        bus_if.req_valid = '0;
        hold_mask        = '0;
        wait_drain("rr4_drain_timeout");
        exp_rr = '{0, 1, 2, 3, 0, 1};
        for (int g = 0; g < 6; g++) chk("rr4_order", 32'(grant_id_log[g]), 32'(exp_rr[g]));
        for (int g = 1; g < 6; g++) chk("rr4_interval", 32'(grant_cyc_log[g] - grant_cyc_log[g-1]), 3);

        // Fairness with requesters 0 and 2 only.
        apply_reset();
        grant_id_log.delete();
        grant_cyc_log.delete();
        hold_mask = 4'b0101;
        set_req(0, 4'd5, 4'd4, 1'b1);
        set_req(2, 4'd6, 4'd7, 1'b0);
        wait_grants(4);
        bus_if.req_valid = '0;
        hold_mask        = '0;
        wait_drain("rr2_drain_timeout");
        exp_rr = '{0, 2, 0, 2, 0, 0};
        for (int g = 0; g < 4; g++) chk("rr2_order", 32'(grant_id_log[g]), 32'(exp_rr[g]));

        // Backpressure: response held, req1 waits until the handshake.
        grant_id_log.delete();
        grant_cyc_log.delete();
        bus_if.rsp_ready = 1'b0;
        set_req(2, 4'd5, 4'd5, 1'b0);
        t = 0;
        while (!bus_if.rsp_valid && t < 20) begin
            tick();
            t++;
        end
        chk("bp_rsp_timeout", 32'(t >= 20), 0);
        set_req(1, 4'd9, 4'd3, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_rsp_valid", 32'(bus_if.rsp_valid), 1);
            chk("bp_rsp_sum", 32'(bus_if.rsp_sum), 32'hA);
            chk("bp_rsp_ovf", 32'(bus_if.rsp_ovf), 1);
            chk("bp_rsp_id", 32'(bus_if.rsp_id), 2);
            chk("bp_req_ready", 32'(bus_if.req_ready), 0);
        end
        bus_if.rsp_ready = 1'b1;
        rise_cyc = cyc;
        wait_grants(2);
        chk("bp_grant_id", 32'(grant_id_log[1]), 1);
        chk("bp_grant_cycle", 32'(grant_cyc_log[1] - rise_cyc), 1);
        wait_drain("bp_drain_timeout");

        // Reset during EXEC discards the operation and restores priority.
        set_req(0, 4'd1, 4'd1, 1'b0);
        tick();
        chk("midop_exec_busy", 32'(busy), 1);
        rst_n            = 1'b0;
        bus_if.req_valid = '0;
        sb.delete();
        tick();
        chk("midop_busy", 32'(busy), 0);
        chk("midop_rsp_valid", 32'(bus_if.rsp_valid), 0);
        chk("midop_op_count", 32'(op_count), 0);
        chk("midop_ovf_count", 32'(ovf_count), 0);
        tick();
        chk("midop_no_rsp", 32'(bus_if.rsp_valid), 0);
        rst_n = 1'b1;
        grant_id_log.delete();
        grant_cyc_log.delete();
        set_req(1, 4'd2, 4'd3, 1'b0);
        set_req(0, 4'd2, 4'd2, 1'b1);
        wait_grants(1);
        chk("midop_first_grant", 32'(grant_id_log[0]), 0);
        wait_drain("midop_drain_timeout");

        // Random operands, requesters and response backpressure.
        for (int it = 0; it < 16; it++) begin
            int r0, r1;
            r0 = $urandom_range(0, NREQ - 1);
            r1 = $urandom_range(0, NREQ - 1);
            set_req(r0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if (r1 != r0) begin
                set_req(r1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            t = 0;
            while ((sb.size() != 0 || busy || bus_if.req_valid != '0) && t < 100) begin
                bus_if.rsp_ready = 1'($urandom_range(0, 1));
                tick();
                t++;
            end
            chk("rand_drain_timeout", 32'(t >= 100), 0);
        end
        bus_if.rsp_ready = 1'b1;

        // Single-requester instance with 4-bit counters.
        chk("n1_rst_op_count", 32'(op_count2), 0);
        rst2_n             = 1'b1;
        bus2_if.req_a      = 4'd7;
        bus2_if.req_b      = 4'd1;
        bus2_if.req_k      = 1'b0;
        bus2_if.req_valid  = 1'b1;
        t = 0;
        while (n_rsp2 < 14 && t < 200) begin
            tick();
            t++;
        end
        chk("n1_op_count_14", 32'(op_count2), 14);
        while (n_rsp2 < 17 && t < 200) begin
            tick();
            t++;
        end
        bus2_if.req_valid = 1'b0;
        chk("n1_timeout", 32'(t >= 200), 0);
        repeat (4) tick();
        chk("n1_op_count_sat", 32'(op_count2), 32'hF);
        chk("n1_ovf_count_sat", 32'(ovf_count2), 32'hF);
        chk("n1_busy_idle", 32'(busy2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
